maple_rx_ctrl: RTL and testbench

//  Receive-frame sequencer for the Maple Bus RX path. Armed by the register block, it waits for
//  the line decoder's start pattern and drives the byte buffer's enable for the frame.
//  It counts bytes, closes the frame on end pattern, overflow, timeout or abort, then waits out
//  the buffer's TLAST drain. It reports byte count, error flags and an interrupt.

---
 rtl/maple_rx_pkg.sv | 20 ++
 rtl/maple_rx_timer.sv | 44 ++++
 rtl/maple_rx_ctrl.sv | 159 +++++++++++++++
 tb/tb_maple_rx_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/maple_rx_pkg.sv
// Shared definitions for the Maple Bus RX frame sequencer: state encoding,
// drain length and status-register error bit positions.
package maple_rx_pkg;

  typedef enum logic [4:0] {
    ST_IDLE    = 5'b00001,
    ST_ARMED   = 5'b00010,
    ST_RECEIVE = 5'b00100,
    ST_DRAIN   = 5'b01000,
    ST_DONE    = 5'b10000
  } rx_state_e;

  localparam int unsigned DRAIN_CYCLES = 2;
  localparam int unsigned DRAIN_W      = 2;

  localparam int unsigned ERR_OVF_BIT = 0;
  localparam int unsigned ERR_TMO_BIT = 1;
  localparam int unsigned ERR_W       = 2;

endpackage

// File: rtl/maple_rx_timer.sv
// Loadable no-progress down-counter; expire_o flags an enabled cycle at zero
// unless that same cycle reloads it.
module maple_rx_timer
  import maple_rx_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned TMO_W          = 17
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [TMO_W-1:0] LOAD_VAL = TMO_W'(TIMEOUT_CYCLES - 32'd1);

  logic [TMO_W-1:0] cnt_q;
  logic [TMO_W-1:0] cnt_d;

  // Next count: reload beats decrement; the counter parks at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (en_i && (cnt_q != {TMO_W{1'b0}})) begin
      cnt_d = cnt_q - {{(TMO_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q <= {TMO_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i & ~load_i & (cnt_q == {TMO_W{1'b0}});

endmodule

// File: rtl/maple_rx_ctrl.sv
// Maple Bus RX frame sequencer: gates the byte buffer for one frame, counts bytes,
// closes on eof/overflow/timeout/abort, drains TLAST, then reports done and irq.
module maple_rx_ctrl
  import maple_rx_pkg::*;
#(
  parameter int unsigned MAX_BYTES      = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned CNT_W          = 11,
  parameter int unsigned TMO_W          = 17
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             arm,
  input  logic             abort,
  input  logic             irq_ack,
  input  logic             sof,
  input  logic             eof,
  input  logic             byte_valid,
  output logic             buf_enable,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] rx_count,
  output logic             err_overflow,
  output logic             err_timeout,
  output logic             irq
);

  localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(MAX_BYTES);
  localparam logic [DRAIN_W-1:0] DRAIN_END = DRAIN_W'(DRAIN_CYCLES - 32'd1);

  rx_state_e          state_q;
  logic               buf_en_q;
  logic               busy_q;
  logic               done_q;
  logic               irq_q;
  logic               aborted_q;
  logic [CNT_W-1:0]   rx_count_q;
  logic [ERR_W-1:0]   err_q;
  logic [DRAIN_W-1:0] drain_cnt_q;

  logic tmr_load_s;
  logic tmr_en_s;
  logic tmr_expire_s;

  // Timer control: loaded on arm, sof and every byte; runs while waiting or receiving.
  always_comb begin
    tmr_load_s = 1'b0;
    tmr_en_s   = 1'b0;
    case (state_q)
      ST_IDLE:    tmr_load_s = arm;
      ST_ARMED:   begin tmr_en_s = 1'b1; tmr_load_s = sof;        end
      ST_RECEIVE: begin tmr_en_s = 1'b1; tmr_load_s = byte_valid; end
      default:    begin tmr_en_s = 1'b0; tmr_load_s = 1'b0;       end
    endcase
  end

  maple_rx_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TMO_W          (TMO_W)
  ) u_timer (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .load_i   (tmr_load_s),
    .en_i     (tmr_en_s),
    .expire_o (tmr_expire_s)
  );

  // Frame FSM with registered outputs; done/irq assert on leaving DONE.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      buf_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      irq_q       <= 1'b0;
      aborted_q   <= 1'b0;
      rx_count_q  <= {CNT_W{1'b0}};
      err_q       <= {ERR_W{1'b0}};
      drain_cnt_q <= {DRAIN_W{1'b0}};
    end else begin
      done_q <= 1'b0;
      if (irq_ack) begin
        irq_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (arm) begin
            state_q    <= ST_ARMED;
            busy_q     <= 1'b1;
            irq_q      <= 1'b0;
            aborted_q  <= 1'b0;
            rx_count_q <= {CNT_W{1'b0}};
            err_q      <= {ERR_W{1'b0}};
          end
        end
        ST_ARMED: begin
          if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (sof) begin
            state_q  <= ST_RECEIVE;
            buf_en_q <= 1'b1;
          end else if (tmr_expire_s) begin
            state_q            <= ST_DONE;
            err_q[ERR_TMO_BIT] <= 1'b1;
          end
        end
        ST_RECEIVE: begin
          // Every exit from RECEIVE funnels into DRAIN; only the flags differ.
          if (abort || eof || byte_valid && (rx_count_q == CNT_MAX) || tmr_expire_s) begin
            state_q     <= ST_DRAIN;
            buf_en_q    <= 1'b0;
            drain_cnt_q <= {DRAIN_W{1'b0}};
          end
          if (abort) begin
            aborted_q <= 1'b1;
          end else if (byte_valid && (rx_count_q == CNT_MAX)) begin
            err_q[ERR_OVF_BIT] <= 1'b1;
          end else begin
            if (byte_valid) begin
              rx_count_q <= rx_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (!eof && tmr_expire_s) begin
              err_q[ERR_TMO_BIT] <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_cnt_q == DRAIN_END) begin
            state_q <= aborted_q ? ST_IDLE : ST_DONE;
            busy_q  <= ~aborted_q;
          end else begin
            drain_cnt_q <= drain_cnt_q + {{(DRAIN_W-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          irq_q   <= 1'b1;
        end
        default: begin
          state_q  <= ST_IDLE;
          buf_en_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign buf_enable   = buf_en_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign irq          = irq_q;
  assign rx_count     = rx_count_q;
  assign err_overflow = err_q[ERR_OVF_BIT];
  assign err_timeout  = err_q[ERR_TMO_BIT];

endmodule

// File: tb/tb_maple_rx_ctrl.sv
// Directed bench for maple_rx_ctrl with MAX_BYTES=8, TIMEOUT_CYCLES=16.
module tb_maple_rx_ctrl;

  localparam int unsigned CNT_W = 4;

  logic             aclk;
  logic             aresetn;
  logic             arm, abort, irq_ack, sof, eof, byte_valid;
  logic             buf_enable, busy, done, err_overflow, err_timeout, irq;
  logic [CNT_W-1:0] rx_count;

  int checks   = 0;
  int failures = 0;

  maple_rx_ctrl #(
    .MAX_BYTES      (8),
    .TIMEOUT_CYCLES (16),
    .CNT_W          (CNT_W),
    .TMO_W          (5)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .arm          (arm),
    .abort        (abort),
    .irq_ack      (irq_ack),
    .sof          (sof),
    .eof          (eof),
    .byte_valid   (byte_valid),
    .buf_enable   (buf_enable),
    .busy         (busy),
    .done         (done),
    .rx_count     (rx_count),
    .err_overflow (err_overflow),
    .err_timeout  (err_timeout),
    .irq          (irq)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    aresetn = 1'b0; arm = 1'b0; abort = 1'b0; irq_ack = 1'b0;
    sof = 1'b0; eof = 1'b0; byte_valid = 1'b0;
    #3;
    chk("rst_buf_en", 32'(buf_enable), 32'd0);
    chk("rst_busy",   32'(busy),       32'd0);
    chk("rst_done",   32'(done),       32'd0);
    chk("rst_count",  32'(rx_count),   32'd0);
    chk("rst_irq",    32'(irq),        32'd0);
    chk("rst_err",    32'({err_overflow, err_timeout}), 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    tick();

    // 1: normal 4-byte frame
    arm = 1'b1; tick(); arm = 1'b0;
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_armed_buf_en", 32'(buf_enable), 32'd0);
    tick();
    sof = 1'b1; tick(); sof = 1'b0;
    chk("t1_sof_buf_en", 32'(buf_enable), 32'd1);
    for (int i = 0; i < 4; i++) begin
      byte_valid = 1'b1; tick(); byte_valid = 1'b0;
    end
    chk("t1_count_pre_eof", 32'(rx_count), 32'd4);
    eof = 1'b1; tick(); eof = 1'b0;
    chk("t1_eof_buf_en", 32'(buf_enable), 32'd0);
    chk("t1_count", 32'(rx_count), 32'd4);
    tick();
    chk("t1_done_c2", 32'(done), 32'd0);
    tick();
    chk("t1_done_c3", 32'(done), 32'd0);
    chk("t1_busy_c3", 32'(busy), 32'd1);
    tick();
    chk("t1_done_c4", 32'(done), 32'd1);
    chk("t1_irq", 32'(irq), 32'd1);
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_err", 32'({err_overflow, err_timeout}), 32'd0);
    tick();
    chk("t1_done_pulse", 32'(done), 32'd0);
    chk("t1_irq_level", 32'(irq), 32'd1);

    // 2: overflow on the 9th byte
    arm = 1'b1; tick(); arm = 1'b0;
    chk("t2_arm_clr_irq", 32'(irq), 32'd0);
    chk("t2_arm_clr_count", 32'(rx_count), 32'd0);
    sof = 1'b1; tick(); sof = 1'b0;
    for (int i = 0; i < 8; i++) begin
      byte_valid = 1'b1; tick(); byte_valid = 1'b0;
    end
    chk("t2_count8", 32'(rx_count), 32'd8);
    chk("t2_no_ovf_yet", 32'(err_overflow), 32'd0);
    byte_valid = 1'b1; tick(); byte_valid = 1'b0;
    chk("t2_ovf", 32'(err_overflow), 32'd1);
    chk("t2_count_sat", 32'(rx_count), 32'd8);
    chk("t2_buf_en", 32'(buf_enable), 32'd0);
    tick(); tick(); tick();
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_ovf_hold", 32'(err_overflow), 32'd1);

    // 3: timeout while armed
    arm = 1'b1; tick(); arm = 1'b0;
    chk("t3_arm_clr_ovf", 32'(err_overflow), 32'd0);
    for (int i = 0; i < 15; i++) begin
      tick();
    end
    chk("t3_no_tmo_15", 32'(err_timeout), 32'd0);
    chk("t3_buf_en_15", 32'(buf_enable), 32'd0);
    tick();
    chk("t3_tmo_16", 32'(err_timeout), 32'd1);
    chk("t3_buf_en_16", 32'(buf_enable), 32'd0);
    tick();
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_count", 32'(rx_count), 32'd0);
    chk("t3_irq", 32'(irq), 32'd1);

    // 4: abort during RECEIVE after 3 bytes
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk("t4_irq_ack", 32'(irq), 32'd0);
    arm = 1'b1; tick(); arm = 1'b0;
    sof = 1'b1; tick(); sof = 1'b0;
    for (int i = 0; i < 3; i++) begin
      byte_valid = 1'b1; tick(); byte_valid = 1'b0;
    end
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t4_buf_en", 32'(buf_enable), 32'd0);
    chk("t4_busy_drain", 32'(busy), 32'd1);
    tick();
    chk("t4_busy_drain2", 32'(busy), 32'd1);
    tick();
    chk("t4_idle", 32'(busy), 32'd0);
    chk("t4_no_done", 32'(done), 32'd0);
    tick();
    chk("t4_no_done2", 32'(done), 32'd0);
    chk("t4_irq", 32'(irq), 32'd0);
    chk("t4_count", 32'(rx_count), 32'd3);

    // 5: byte with eof, arm ignored mid-frame, irq_ack loses to set
    arm = 1'b1; tick(); arm = 1'b0;
    sof = 1'b1; tick(); sof = 1'b0;
    for (int i = 0; i < 2; i++) begin
      byte_valid = 1'b1; tick(); byte_valid = 1'b0;
    end
    arm = 1'b1; tick(); arm = 1'b0;
    chk("t5_arm_ign_buf", 32'(buf_enable), 32'd1);
    chk("t5_arm_ign_cnt", 32'(rx_count), 32'd2);
    byte_valid = 1'b1; eof = 1'b1; tick(); byte_valid = 1'b0; eof = 1'b0;
    chk("t5_count3", 32'(rx_count), 32'd3);
    chk("t5_buf_en", 32'(buf_enable), 32'd0);
    tick(); tick();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_set_wins", 32'(irq), 32'd1);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk("t5_irq_ack", 32'(irq), 32'd0);

    // 6: async reset mid-frame, then a clean frame
    arm = 1'b1; tick(); arm = 1'b0;
    sof = 1'b1; tick(); sof = 1'b0;
    byte_valid = 1'b1; tick(); byte_valid = 1'b0;
    chk("t6_buf_en_pre", 32'(buf_enable), 32'd1);
    #2;
    aresetn = 1'b0;
    #1;
    chk("t6_rst_buf_en", 32'(buf_enable), 32'd0);
    chk("t6_rst_busy",   32'(busy),       32'd0);
    chk("t6_rst_done",   32'(done),       32'd0);
    chk("t6_rst_irq",    32'(irq),        32'd0);
    tick(); tick();
    aresetn = 1'b1;
    tick();
    arm = 1'b1; tick(); arm = 1'b0;
    chk("t6_rearm_busy", 32'(busy), 32'd1);
    chk("t6_rearm_count", 32'(rx_count), 32'd0);
    sof = 1'b1; tick(); sof = 1'b0;
    byte_valid = 1'b1; tick(); byte_valid = 1'b0;
    eof = 1'b1; tick(); eof = 1'b0;
    tick(); tick(); tick();
    chk("t6_done", 32'(done), 32'd1);
    chk("t6_count", 32'(rx_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
